// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register, writeback select, 32x32 register
// file with write-through bypass, forwarding export and sticky halt.
// Optional retire/load statistics counters are enabled by defining
// MEM_WB_STATS_EN; without it the counter ports and logic are absent.
module mem_wb_stage #(
    parameter int DATA     = 32,
    parameter int REG_ADDR = 5,
    parameter int NUM_REGS = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mem_valid_i,
    input  logic [DATA-1:0]     mem_data_i,
    input  logic [DATA-1:0]     alu_result_i,
    input  logic [REG_ADDR-1:0] rd_i,
    input  logic                reg_write_i,
    input  logic                mem_to_reg_i,
    input  logic                halt_i,
    input  logic                stall_i,
    input  logic                flush_i,
    input  logic [REG_ADDR-1:0] rs_addr_i,
    input  logic [REG_ADDR-1:0] rt_addr_i,
    output logic [DATA-1:0]     rs_data_o,
    output logic [DATA-1:0]     rt_data_o,
    output logic                wb_valid_o,
    output logic                wb_we_o,
    output logic [REG_ADDR-1:0] wb_rd_o,
    output logic [DATA-1:0]     wb_data_o,
    output logic                halted_o
`ifdef MEM_WB_STATS_EN
    ,
    output logic [31:0]         retired_count_o,
    output logic [31:0]         load_count_o
`endif
);

    // MEM/WB register fields
    logic                valid_q, valid_d;
    logic                reg_write_q, reg_write_d;
    logic                halt_q, halt_d;
    logic [REG_ADDR-1:0] rd_q, rd_d;
    logic [DATA-1:0]     data_q, data_d;
    // Set once the entry in WB has had its single commit cycle
    logic                retired_q, retired_d;
    logic                halted_q, halted_d;

    // Register file storage; entry 0 is never written
    logic [DATA-1:0]     rf_q [NUM_REGS];

    // The entry in WB commits during this cycle (first valid cycle, not frozen)
    logic                retire_evt;
    logic                we;

    assign retire_evt = valid_q & ~retired_q & ~halted_q;
    // A HALT entry never writes a register, even if reg_write is set
    assign we         = retire_evt & reg_write_q & ~halt_q & (rd_q != '0);

    // Next-state for the pipeline register: freeze > flush > stall > capture
    always_comb begin
        valid_d     = valid_q;
        reg_write_d = reg_write_q;
        halt_d      = halt_q;
        rd_d        = rd_q;
        data_d      = data_q;
        retired_d   = retired_q;
        halted_d    = halted_q | (retire_evt & halt_q);
        if (!halted_q) begin
            if (flush_i) begin
                valid_d   = 1'b0;
                retired_d = 1'b0;
            end else if (stall_i) begin
                retired_d = retired_q | valid_q;
            end else begin
                valid_d     = mem_valid_i;
                reg_write_d = reg_write_i;
                halt_d      = halt_i;
                rd_d        = rd_i;
                data_d      = mem_to_reg_i ? mem_data_i : alu_result_i;
                retired_d   = 1'b0;
            end
        end
    end

    // Pipeline register, retire flag and sticky halt state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            halt_q      <= 1'b0;
            rd_q        <= '0;
            data_q      <= '0;
            retired_q   <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            halt_q      <= halt_d;
            rd_q        <= rd_d;
            data_q      <= data_d;
            retired_q   <= retired_d;
            halted_q    <= halted_d;
        end
    end

    // One register per file entry, written when the committing entry targets it
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_rf
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rf_q[gi] <= '0;
                end else if (we && (rd_q == REG_ADDR'(gi))) begin
                    rf_q[gi] <= data_q;
                end
            end
        end
    endgenerate

    // Read port A: R0 is zero, bypass the in-flight write, else the array
    always_comb begin
        rs_data_o = '0;
        if (rs_addr_i != '0) begin
            if (we && (rs_addr_i == rd_q)) begin
                rs_data_o = data_q;
            end else begin
                rs_data_o = rf_q[rs_addr_i];
            end
        end
    end

    // Read port B: same rules as port A
    always_comb begin
        rt_data_o = '0;
        if (rt_addr_i != '0) begin
            if (we && (rt_addr_i == rd_q)) begin
                rt_data_o = data_q;
            end else begin
                rt_data_o = rf_q[rt_addr_i];
            end
        end
    end

    assign wb_valid_o = valid_q;
    assign wb_we_o    = we;
    assign wb_rd_o    = rd_q;
    assign wb_data_o  = data_q;
    assign halted_o   = halted_q;

`ifdef MEM_WB_STATS_EN
    logic        mem_to_reg_q;
    logic [31:0] retired_count_q;
    logic [31:0] load_count_q;

    // Load flag of the WB entry, tracked only for the load counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_to_reg_q <= 1'b0;
        end else if (!halted_q && !flush_i && !stall_i) begin
            mem_to_reg_q <= mem_to_reg_i;
        end
    end

    // Count each entry exactly once, at its commit cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_count_q <= '0;
            load_count_q    <= '0;
        end else if (retire_evt) begin
            retired_count_q <= retired_count_q + 32'd1;
            if (mem_to_reg_q) begin
                load_count_q <= load_count_q + 32'd1;
            end
        end
    end

    assign retired_count_o = retired_count_q;
    assign load_count_o    = load_count_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Testbench for mem_wb_stage: directed table, reset corner cases and a
// randomized run against a behavioural commit model.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid_i, reg_write_i, mem_to_reg_i, halt_i, stall_i, flush_i;
    logic [31:0] mem_data_i, alu_result_i;
    logic [4:0]  rd_i, rs_addr_i, rt_addr_i;
    logic [31:0] rs_data_o, rt_data_o, wb_data_o;
    logic        wb_valid_o, wb_we_o, halted_o;
    logic [4:0]  wb_rd_o;
`ifdef MEM_WB_STATS_EN
    logic [31:0] retired_count_o, load_count_o;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk(clk), .reset(reset),
        .mem_valid_i(mem_valid_i), .mem_data_i(mem_data_i), .alu_result_i(alu_result_i),
        .rd_i(rd_i), .reg_write_i(reg_write_i), .mem_to_reg_i(mem_to_reg_i),
        .halt_i(halt_i), .stall_i(stall_i), .flush_i(flush_i),
        .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i),
        .rs_data_o(rs_data_o), .rt_data_o(rt_data_o),
        .wb_valid_o(wb_valid_o), .wb_we_o(wb_we_o), .wb_rd_o(wb_rd_o),
        .wb_data_o(wb_data_o), .halted_o(halted_o)
`ifdef MEM_WB_STATS_EN
        , .retired_count_o(retired_count_o), .load_count_o(load_count_o)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r, input logic h,
                         input logic s, input logic f, input logic [4:0] rd,
                         input logic [31:0] mem, input logic [31:0] alu,
                         input logic [4:0] rs, input logic [4:0] rt);
        mem_valid_i = v; reg_write_i = rw; mem_to_reg_i = m2r; halt_i = h;
        stall_i = s; flush_i = f; rd_i = rd; mem_data_i = mem; alu_result_i = alu;
        rs_addr_i = rs; rt_addr_i = rt;
    endtask

    // ---------------- behavioural model ----------------
    // Architectural registers plus the single instruction sitting in WB.
    // That instruction commits exactly once, in its first cycle in WB.
    logic [31:0] m_regs [32];
    logic        m_valid, m_rw, m_m2r, m_halt, m_done, m_halted;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    int unsigned m_retired, m_loads;

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_valid = 0; m_rw = 0; m_m2r = 0; m_halt = 0; m_done = 0; m_halted = 0;
        m_rd = 0; m_data = 0; m_retired = 0; m_loads = 0;
    endtask

    function automatic logic m_commits_now();
        return m_valid && !m_done && !m_halted;
    endfunction

    function automatic logic m_writes_now();
        return m_commits_now() && !m_halt && m_rw && (m_rd != 5'd0);
    endfunction

    // Architectural value a reader sees: the committing write is visible at once
    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (m_writes_now() && a == m_rd) return m_data;
        return m_regs[a];
    endfunction

    task automatic m_edge();
        if (m_halted) return;
        if (m_commits_now()) begin
            m_retired++;
            if (m_m2r) m_loads++;
            if (m_halt) m_halted = 1;
            else if (m_writes_now()) m_regs[m_rd] = m_data;
        end
        if (flush_i) begin
            m_valid = 0;
        end else if (stall_i) begin
            if (m_valid) m_done = 1;
        end else begin
            m_valid = mem_valid_i; m_rw = reg_write_i; m_m2r = mem_to_reg_i;
            m_halt = halt_i; m_rd = rd_i; m_done = 0;
            m_data = mem_to_reg_i ? mem_data_i : alu_result_i;
        end
    endtask

    task automatic m_compare();
        chk("rnd_valid",  {31'd0, wb_valid_o}, {31'd0, m_valid});
        chk("rnd_we",     {31'd0, wb_we_o},    {31'd0, m_writes_now()});
        chk("rnd_halted", {31'd0, halted_o},   {31'd0, m_halted});
        chk("rnd_rs",     rs_data_o, m_read(rs_addr_i));
        chk("rnd_rt",     rt_data_o, m_read(rt_addr_i));
        if (m_valid) begin
            chk("rnd_wb_rd",   {27'd0, wb_rd_o}, {27'd0, m_rd});
            chk("rnd_wb_data", wb_data_o, m_data);
        end
`ifdef MEM_WB_STATS_EN
        chk("rnd_retired_cnt", retired_count_o, m_retired);
        chk("rnd_load_cnt",    load_count_o,    m_loads);
`endif
    endtask

    // Asynchronous reset pulse in the low phase, released on a later low phase
    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_valid",  {31'd0, wb_valid_o}, 32'd0);
        chk("rst_halted", {31'd0, halted_o},   32'd0);
        chk("rst_data",   wb_data_o, 32'd0);
        m_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        v, rw, m2r, h, s, f;
        logic [4:0]  rd, rs, rt;
        logic [31:0] mem, alu;
        logic        e_valid, e_we, e_halted;
        logic [31:0] e_data, e_rs, e_rt;
    } vec_t;

    vec_t tbl [11];

    initial begin
        // v rw m2r h s f  rd  rs rt   mem        alu         valid we halted data        rs          rt
        tbl[0]  = '{1,1,0,0,0,0, 8, 8, 0, 32'h0,  32'hDEADBEEF, 1,1,0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
        tbl[1]  = '{0,0,0,0,0,0, 0, 8, 8, 32'h0,  32'h0,        0,0,0, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF};
        tbl[2]  = '{1,1,1,0,0,0, 3, 3, 8, 32'h42, 32'h100,      1,1,0, 32'h42,       32'h42,       32'hDEADBEEF};
        tbl[3]  = '{1,1,0,0,0,0, 0, 0, 3, 32'h0,  32'hFFFF,     1,0,0, 32'hFFFF,     32'h0,        32'h42};
        tbl[4]  = '{1,1,0,0,0,0, 4, 4, 4, 32'h0,  32'h44,       1,1,0, 32'h44,       32'h44,       32'h44};
        tbl[5]  = '{1,1,0,0,1,0, 7, 4, 7, 32'h0,  32'h77,       1,0,0, 32'h44,       32'h44,       32'h0};
        tbl[6]  = '{1,1,0,0,1,0, 7, 4, 7, 32'h0,  32'h77,       1,0,0, 32'h44,       32'h44,       32'h0};
        tbl[7]  = '{1,1,0,0,1,0, 7, 4, 7, 32'h0,  32'h77,       1,0,0, 32'h44,       32'h44,       32'h0};
        tbl[8]  = '{1,1,0,0,1,1, 5, 5, 4, 32'h0,  32'h55,       0,0,0, 32'h44,       32'h0,        32'h44};
        tbl[9]  = '{1,0,0,1,0,0, 0, 0, 0, 32'h0,  32'h0,        1,0,0, 32'h0,        32'h0,        32'h0};
        tbl[10] = '{1,1,0,0,0,0, 9, 9, 3, 32'h0,  32'h55,       1,0,1, 32'h55,       32'h0,        32'h42};
    end

    initial begin
`ifdef MEM_WB_STATS_EN
        logic [31:0] cnt_base;
`endif
        int halt_cycles;
        reset = 1'b1;
        drive(0,0,0,0,0,0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state: all outputs zero, every register reads zero
        chk("reset_wb_valid", {31'd0, wb_valid_o}, 32'd0);
        chk("reset_wb_we",    {31'd0, wb_we_o},    32'd0);
        chk("reset_halted",   {31'd0, halted_o},   32'd0);
        chk("reset_wb_rd",    {27'd0, wb_rd_o},    32'd0);
        for (int a = 0; a < 32; a++) begin
            rs_addr_i = 5'(a); rt_addr_i = 5'(31 - a);
            #1;
            chk("reset_rs", rs_data_o, 32'd0);
            chk("reset_rt", rt_data_o, 32'd0);
        end
        reset = 1'b0;

        // Reset in the middle of a pending write to R5 drops the write
        drive(1,1,0,0,0,0, 5, 0, 32'h1234, 5, 5);
        @(posedge clk); @(negedge clk);
        chk("midrst_we_before",  {31'd0, wb_we_o}, 32'd1);
        chk("midrst_bypass",     rs_data_o, 32'h1234);
        reset = 1'b1;
        #1;
        chk("midrst_we_in_rst",  {31'd0, wb_we_o}, 32'd0);
        chk("midrst_rs_in_rst",  rs_data_o, 32'd0);
        chk("midrst_valid",      {31'd0, wb_valid_o}, 32'd0);
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        drive(0,0,0,0,0,0, 0, 0, 0, 5, 5);
        #1;
        chk("midrst_r5_after",   rs_data_o, 32'd0);
        @(posedge clk); @(negedge clk);
        chk("midrst_r5_later",   rt_data_o, 32'd0);

        // Directed table: each row is captured, then checked in its WB cycle
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].v, tbl[i].rw, tbl[i].m2r, tbl[i].h, tbl[i].s, tbl[i].f,
                  tbl[i].rd, tbl[i].mem, tbl[i].alu, tbl[i].rs, tbl[i].rt);
            @(posedge clk); @(negedge clk);
            chk($sformatf("tbl%0d_valid", i),  {31'd0, wb_valid_o}, {31'd0, tbl[i].e_valid});
            chk($sformatf("tbl%0d_we", i),     {31'd0, wb_we_o},    {31'd0, tbl[i].e_we});
            chk($sformatf("tbl%0d_halted", i), {31'd0, halted_o},   {31'd0, tbl[i].e_halted});
            chk($sformatf("tbl%0d_data", i),   wb_data_o, tbl[i].e_data);
            chk($sformatf("tbl%0d_rs", i),     rs_data_o, tbl[i].e_rs);
            chk($sformatf("tbl%0d_rt", i),     rt_data_o, tbl[i].e_rt);
`ifdef MEM_WB_STATS_EN
            if (i == 4) cnt_base = retired_count_o;
            if (i == 7) chk("stall_retire_once", retired_count_o, cnt_base + 32'd1);
`endif
        end

        // Halted core ignores further writes and stays halted
        drive(1,1,0,0,0,0, 9, 0, 32'h66, 9, 9);
        repeat (3) begin
            @(posedge clk); @(negedge clk);
        end
        chk("halt_r9_unchanged", rs_data_o, 32'd0);
        chk("halt_sticky",       {31'd0, halted_o}, 32'd1);

        // Randomized run against the model
        do_reset();
        halt_cycles = 0;
        for (int n = 0; n < 600; n++) begin
            if ((m_halted && halt_cycles > 3) || ($urandom_range(99) == 0)) begin
                do_reset();
                halt_cycles = 0;
            end
            mem_valid_i  = ($urandom_range(9) != 0);
            reg_write_i  = ($urandom_range(4) != 0);
            mem_to_reg_i = $urandom_range(1);
            halt_i       = ($urandom_range(59) == 0);
            stall_i      = ($urandom_range(5) == 0);
            flush_i      = ($urandom_range(9) == 0);
            rd_i         = 5'($urandom_range(7));
            mem_data_i   = $urandom;
            alu_result_i = $urandom;
            rs_addr_i    = 5'($urandom_range(7));
            rt_addr_i    = ($urandom_range(3) == 0) ? 5'($urandom) : 5'($urandom_range(7));
            #1;
            m_compare();
            @(posedge clk);
            m_edge();
            if (m_halted) halt_cycles++;
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
